// File: rtl/csr_trap_sequencer.sv
// Owns the CSR file write port and read index: forwards WBU writes / IDU reads when idle,
// and runs the fixed CSR update sequences for trap entry and mret before redirecting the PC.
module csr_trap_sequencer #(
    parameter int         XLEN     = 32,
    parameter logic [1:0] MRET_MPP = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    output logic            trap_ready,
    input  logic            trap_is_mret,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [2:0]      WBU_csr_rd_i,
    input  logic            WBU_CSRWr_i,
    input  logic [XLEN-1:0] WBU_csr_busW_i,
    output logic            wbu_csr_ready,
    input  logic [2:0]      IDU_csr_rs_i,
    output logic            idu_csr_stall,
    output logic [2:0]      csr_rs_o,
    input  logic [XLEN-1:0] csr_rs_data_i,
    output logic            CSRWr_o,
    output logic [2:0]      csr_rd_o,
    output logic [XLEN-1:0] csr_busW_o,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, M0, M1, M2, DONE} state_t;

    localparam logic [2:0] IDX_MSTATUS = 3'd0;
    localparam logic [2:0] IDX_MTVEC   = 3'd1;
    localparam logic [2:0] IDX_MEPC    = 3'd2;
    localparam logic [2:0] IDX_MCAUSE  = 3'd3;
    localparam logic [2:0] IDX_LAST    = 3'd5;

    // mstatus fields touched by the sequences: MPP[12:11], MPIE[7], MIE[3]
    localparam logic [XLEN-1:0] MST_FIELDS = XLEN'('h1888);

    state_t          state_reg;
    logic [XLEN-1:0] tgt_reg;
    logic [XLEN-1:0] mst_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] cause_reg;

    logic [XLEN-1:0] trap_fields;
    logic [XLEN-1:0] mret_fields;
    logic [XLEN-1:0] mst_trap_next;
    logic [XLEN-1:0] mst_mret_next;

    always_comb begin
        trap_fields      = '0;
        trap_fields[12:11] = 2'b11;
        trap_fields[7]   = mst_reg[3];
        mret_fields      = '0;
        mret_fields[12:11] = MRET_MPP;
        mret_fields[7]   = 1'b1;
        mret_fields[3]   = mst_reg[7];
        mst_trap_next    = (mst_reg & ~MST_FIELDS) | trap_fields;
        mst_mret_next    = (mst_reg & ~MST_FIELDS) | mret_fields;
    end

    always_comb begin
        csr_rs_o       = IDU_csr_rs_i;
        csr_rd_o       = WBU_csr_rd_i;
        csr_busW_o     = WBU_csr_busW_i;
        CSRWr_o        = 1'b0;
        wbu_csr_ready  = 1'b0;
        idu_csr_stall  = 1'b1;
        trap_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = tgt_reg;
        busy           = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                idu_csr_stall = 1'b0;
                wbu_csr_ready = 1'b1;
                // Gated by rst so nothing leaks to the CSR file while held in reset
                CSRWr_o    = rst & WBU_CSRWr_i & (WBU_csr_rd_i <= IDX_LAST);
                trap_ready = rst & trap_valid & ~WBU_CSRWr_i;
            end
            T0: begin
                csr_rs_o   = IDX_MTVEC;
                CSRWr_o    = 1'b1;
                csr_rd_o   = IDX_MEPC;
                csr_busW_o = pc_reg;
            end
            T1: begin
                csr_rs_o   = IDX_MSTATUS;
                CSRWr_o    = 1'b1;
                csr_rd_o   = IDX_MCAUSE;
                csr_busW_o = cause_reg;
            end
            T2: begin
                CSRWr_o    = 1'b1;
                csr_rd_o   = IDX_MSTATUS;
                csr_busW_o = mst_trap_next;
            end
            M0: csr_rs_o = IDX_MEPC;
            M1: csr_rs_o = IDX_MSTATUS;
            M2: begin
                CSRWr_o    = 1'b1;
                csr_rd_o   = IDX_MSTATUS;
                csr_busW_o = mst_mret_next;
            end
            DONE: redirect_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            tgt_reg   <= '0;
            mst_reg   <= '0;
            pc_reg    <= '0;
            cause_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (trap_ready) begin
                        pc_reg    <= trap_pc;
                        cause_reg <= trap_cause;
                        state_reg <= trap_is_mret ? M0 : T0;
                    end
                end
                T0: begin
                    tgt_reg   <= {csr_rs_data_i[XLEN-1:2], 2'b00};
                    state_reg <= T1;
                end
                T1: begin
                    mst_reg   <= csr_rs_data_i;
                    state_reg <= T2;
                end
                T2: state_reg <= DONE;
                M0: begin
                    tgt_reg   <= csr_rs_data_i;
                    state_reg <= M1;
                end
                M1: begin
                    mst_reg   <= csr_rs_data_i;
                    state_reg <= M2;
                end
                M2: state_reg <= DONE;
                DONE: if (redirect_ready) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
